sr_config_tx: RTL and testbench
===============================

// Module: sr_config_tx
// PURPOSE
// - Host-side serial transmitter for the pulse-divider configuration port. Converts one
//   parallel command (16-bit divider value or row-size value, or a clear) into the sr_data /
//   sr_clk / sr_sel_* / sr_clr_* waveform the divider core samples on sr_clk rising edge.
// - Owns divide_enable and en_internals: forces both low while a frame is on the wire and
//   restores them afterwards, so the core never divides while a register is being rewritten.
// PARAMETERS
// - WORD_W       16  bits per frame, sent MSB first
// - HALF_CYCLES  2   clk cycles per sr_clk half-period (>=1)
// - GUARD_CYCLES 4   clk cycles between enables dropping and sel asserting (>=1)
// PORTS
// - clk           in   1       system clock; all logic on rising edge
// - rst_n         in   1       reset, asynchronous, active-low
// - cmd_valid     in   1       command offered
// - cmd_ready     out  1       high only in IDLE; cmd accepted when valid&ready
// - cmd_target    in   1       0 = divider register, 1 = row-size register
// - cmd_clear     in   1       1 = issue clear pulse to target instead of shifting data
// - cmd_data      in   WORD_W  value to shift; ignored when cmd_clear=1
// - run_req       in   1       host wants divider running
// - busy          out  1       high from accept cycle+1 until done
// - done          out  1       one-cycle pulse when frame completes
// - sr_data       out  1       serial data, stable across each sr_clk rising edge
// - sr_clk        out  1       serial clock, idles low
// - sr_sel_div    out  1       divider register select
// - sr_sel_row    out  1       row-size register select
// - sr_clr_div    out  1       divider register clear
// - sr_clr_row    out  1       row-size register clear
// - divide_enable out  1       run_req gated by IDLE, registered
// - en_internals  out  1       identical to divide_enable
// BEHAVIOUR
// - Reset (async): every output 0 except cmd_ready=1 once rst_n high; state IDLE; counters 0.
// - All outputs registered. divide_enable = en_internals = run_req & (state==IDLE), 1-cycle lag.
// - States: IDLE -> QUIESCE -> SELECT -> SHIFT_LO <-> SHIFT_HI -> HOLD -> IDLE; clear path
//   IDLE -> QUIESCE -> CLEAR -> IDLE.
// - IDLE: accept latches target/clear/data into shadow regs; cmd_* changes later are ignored.
// - QUIESCE (GUARD_CYCLES): enables 0, sel 0, sr_clk 0.
// - SELECT (HALF_CYCLES): chosen sel=1, sr_clk 0, sr_data 0.
// - SHIFT_LO (HALF_CYCLES): sr_clk 0, sr_data = shadow[WORD_W-1-bit_idx] set on entry.
// - SHIFT_HI (HALF_CYCLES): sr_clk 1, sr_data held; on exit bit_idx++; after bit WORD_W-1 -> HOLD.
// - HOLD (HALF_CYCLES): sr_clk 0, sel held 1; on exit sel 0, done=1, return IDLE.
// - CLEAR (HALF_CYCLES): chosen sr_clr_*=1, sel 0, sr_clk 0; on exit clr 0, done=1.
// - Exactly WORD_W sr_clk rising edges per data frame; zero in clear frame; never both sels
//   nor sel and clr together.
// - Data frame busy length = GUARD_CYCLES + HALF_CYCLES*(2+2*WORD_W); defaults: 72 cycles.
//   Clear frame = GUARD_CYCLES + HALF_CYCLES; defaults: 6 cycles.
// - bit_idx width $clog2(WORD_W); phase counter width $clog2(max(HALF,GUARD)+1); no wrap
//   beyond WORD_W-1. Any value incl. 0 transmitted verbatim (range checks are host's job).
// - Back-to-back: cmd_ready rises the cycle after done; sel low for >=GUARD_CYCLES+1 between
//   frames. run_req toggling mid-frame has no effect until IDLE.
// - rst_n low mid-frame: sel/clr/sr_clk/sr_data/enables drop immediately; frame abandoned,
//   no done pulse.
// STRUCTURE
// - Package sr_config_pkg: state enum, TGT_DIV=1'b0 / TGT_ROW=1'b1, default WORD_W.
// - Sub-module sr_phase_timer: loadable down-counter with terminal-count flag, used for
//   GUARD and HALF periods. FSM + shadow shift reg stay in sr_config_tx.
// TESTING
// - Divider load 16'd2, run_req=1: enables low 1 cyc after accept; 16 rising edges; bench
//   sampler on sr_clk posedge reads 0x0002; sr_sel_div=1, sr_sel_row=0; done at cycle 72;
//   enables high the cycle after done.
// - Reload 16'd6 while running: same waveform, sampled 0x0006; no sr_clk edge while
//   divide_enable=1; sel low before enables return.
// - Row load 16'hA5C3 (target=1): sampled 0xA5C3 on sr_sel_row; sr_sel_div never 1.
// - Clear divider: sr_clr_div=1 for exactly 2 cycles, 0 sr_clk edges, done at cycle 6.
// - rst_n low during bit 7 HI phase: all outputs 0 same timestep; after release cmd_ready=1,
//   next 16'h8001 frame samples correctly.
// - cmd_valid held with two queued commands: second accepted cycle after first done; sel
//   low >=5 cycles between frames; both values sampled intact.

Source files
------------

// File: rtl/sr_config_pkg.sv
// Shared definitions for the pulse-divider configuration transmitter.
//   sr_state_t     : transmitter FSM states
//   TGT_DIV/TGT_ROW: command target codes (also the index into the sel/clr vectors)
//   WORD_W_DEFAULT : default frame width
//   max_int        : elaboration-time helper for counter sizing
package sr_config_pkg;

    localparam int WORD_W_DEFAULT = 16;

    localparam logic TGT_DIV = 1'b0;
    localparam logic TGT_ROW = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_QUIESCE,
        S_SELECT,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_HOLD,
        S_CLEAR
    } sr_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sr_phase_timer.sv
// Loadable down-counter used to time the guard and half-period phases.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : phase length minus one
//   tc         : terminal count, high while the counter sits at zero
module sr_phase_timer #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign tc = (count_reg == '0);

endmodule

// File: rtl/sr_config_tx.sv
// Host-side serial transmitter for the pulse-divider configuration port.
// Takes one parallel command (load divider / load row size / clear) and
// produces the sr_* waveform, quiescing the divider enables around it.
//   cmd_valid/cmd_ready/cmd_target/cmd_clear/cmd_data : command handshake
//   run_req                       : host wants the divider running
//   busy, done                    : frame in progress / one-cycle completion pulse
//   sr_data, sr_clk               : serial data and clock (MSB first, clock idles low)
//   sr_sel_div/row, sr_clr_div/row: register selects and clear strobes
//   divide_enable, en_internals   : run_req gated by IDLE (one-cycle lag)
module sr_config_tx
    import sr_config_pkg::*;
#(
    parameter int WORD_W       = WORD_W_DEFAULT,
    parameter int HALF_CYCLES  = 2,
    parameter int GUARD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_target,
    input  logic              cmd_clear,
    input  logic [WORD_W-1:0] cmd_data,
    input  logic              run_req,
    output logic              busy,
    output logic              done,
    output logic              sr_data,
    output logic              sr_clk,
    output logic              sr_sel_div,
    output logic              sr_sel_row,
    output logic              sr_clr_div,
    output logic              sr_clr_row,
    output logic              divide_enable,
    output logic              en_internals
);

    localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int PH_W  = $clog2(max_int(HALF_CYCLES, GUARD_CYCLES) + 1);

    localparam logic [PH_W-1:0]  HALF_LOAD  = PH_W'(HALF_CYCLES - 1);
    localparam logic [PH_W-1:0]  GUARD_LOAD = PH_W'(GUARD_CYCLES - 1);
    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(WORD_W - 1);

    sr_state_t         state_reg, state_next;
    logic [BIT_W-1:0]  bit_idx_reg, bit_idx_next;
    logic [WORD_W-1:0] shadow_reg, shadow_next;
    logic              tgt_reg, tgt_next;
    logic              clear_reg, clear_next;

    logic              cmd_ready_reg, cmd_ready_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              sr_data_reg, sr_data_next;
    logic              sr_clk_reg, sr_clk_next;
    logic [1:0]        sel_reg, sel_next;
    logic [1:0]        clr_reg, clr_next;
    logic              enable_reg, enable_next;

    logic              tmr_load;
    logic [PH_W-1:0]   tmr_load_val;
    logic              tmr_tc;
    logic              sel_phase;

    sr_phase_timer #(
        .CNT_W (PH_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .tc       (tmr_tc)
    );

    always_comb begin
        state_next   = state_reg;
        bit_idx_next = bit_idx_reg;
        shadow_next  = shadow_reg;
        tgt_next     = tgt_reg;
        clear_next   = clear_reg;
        tmr_load     = 1'b0;
        tmr_load_val = HALF_LOAD;
        done_next    = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_reg) begin
                    state_next   = S_QUIESCE;
                    tgt_next     = cmd_target;
                    clear_next   = cmd_clear;
                    shadow_next  = cmd_data;
                    bit_idx_next = '0;
                    tmr_load     = 1'b1;
                    tmr_load_val = GUARD_LOAD;
                end
            end
            S_QUIESCE: begin
                if (tmr_tc) begin
                    state_next = clear_reg ? S_CLEAR : S_SELECT;
                    tmr_load   = 1'b1;
                end
            end
            S_SELECT: begin
                if (tmr_tc) begin
                    state_next = S_SHIFT_LO;
                    tmr_load   = 1'b1;
                end
            end
            S_SHIFT_LO: begin
                if (tmr_tc) begin
                    state_next = S_SHIFT_HI;
                    tmr_load   = 1'b1;
                end
            end
            S_SHIFT_HI: begin
                if (tmr_tc) begin
                    tmr_load = 1'b1;
                    // The next bit always sits in the shadow MSB.
                    shadow_next = shadow_reg << 1;
                    if (bit_idx_reg == LAST_BIT) begin
                        state_next = S_HOLD;
                    end else begin
                        state_next   = S_SHIFT_LO;
                        bit_idx_next = bit_idx_reg + 1'b1;
                    end
                end
            end
            S_HOLD, S_CLEAR: begin
                if (tmr_tc) begin
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    assign sel_phase = (state_next == S_SELECT) || (state_next == S_SHIFT_LO) ||
                       (state_next == S_SHIFT_HI) || (state_next == S_HOLD);

    always_comb begin
        sr_clk_next  = (state_next == S_SHIFT_HI);
        sr_data_next = ((state_next == S_SHIFT_LO) || (state_next == S_SHIFT_HI)) ?
                       shadow_next[WORD_W-1] : 1'b0;
        busy_next    = (state_next != S_IDLE);
        // Ready stays low in the done cycle and returns one cycle later.
        cmd_ready_next = (state_next == S_IDLE) && (state_reg == S_IDLE);
        enable_next    = run_req && (state_reg == S_IDLE);
    end

    // Index into sel/clr vectors equals the target code.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_tgt
            assign sel_next[gi] = sel_phase && (tgt_next == 1'(gi));
            assign clr_next[gi] = (state_next == S_CLEAR) && (tgt_next == 1'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            bit_idx_reg   <= '0;
            shadow_reg    <= '0;
            tgt_reg       <= 1'b0;
            clear_reg     <= 1'b0;
            cmd_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            sr_data_reg   <= 1'b0;
            sr_clk_reg    <= 1'b0;
            sel_reg       <= '0;
            clr_reg       <= '0;
            enable_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bit_idx_reg   <= bit_idx_next;
            shadow_reg    <= shadow_next;
            tgt_reg       <= tgt_next;
            clear_reg     <= clear_next;
            cmd_ready_reg <= cmd_ready_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            sr_data_reg   <= sr_data_next;
            sr_clk_reg    <= sr_clk_next;
            sel_reg       <= sel_next;
            clr_reg       <= clr_next;
            enable_reg    <= enable_next;
        end
    end

    assign cmd_ready     = cmd_ready_reg;
    assign busy          = busy_reg;
    assign done          = done_reg;
    assign sr_data       = sr_data_reg;
    assign sr_clk        = sr_clk_reg;
    assign sr_sel_div    = sel_reg[0];
    assign sr_sel_row    = sel_reg[1];
    assign sr_clr_div    = clr_reg[0];
    assign sr_clr_row    = clr_reg[1];
    assign divide_enable = enable_reg;
    assign en_internals  = enable_reg;

endmodule

// File: tb/tb_sr_config_tx.sv
// Self-checking bench for sr_config_tx: directed frames from the feature list
// plus randomized commands, each judged against frame-level expectations.
module tb_sr_config_tx;

    localparam int W     = 16;
    localparam int HALF  = 2;
    localparam int GUARD = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_target = 1'b0;
    logic         cmd_clear = 1'b0;
    logic [W-1:0] cmd_data = '0;
    logic         run_req = 1'b0;
    logic         cmd_ready, busy, done, sr_data, sr_clk;
    logic         sr_sel_div, sr_sel_row, sr_clr_div, sr_clr_row;
    logic         divide_enable, en_internals;

    sr_config_tx #(
        .WORD_W       (W),
        .HALF_CYCLES  (HALF),
        .GUARD_CYCLES (GUARD)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_target    (cmd_target),
        .cmd_clear     (cmd_clear),
        .cmd_data      (cmd_data),
        .run_req       (run_req),
        .busy          (busy),
        .done          (done),
        .sr_data       (sr_data),
        .sr_clk        (sr_clk),
        .sr_sel_div    (sr_sel_div),
        .sr_sel_row    (sr_sel_row),
        .sr_clr_div    (sr_clr_div),
        .sr_clr_row    (sr_clr_row),
        .divide_enable (divide_enable),
        .en_internals  (en_internals)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    // Receiver model: shift in sr_data on each sr_clk rising edge, as the core does.
    logic [W-1:0] rx_word = '0;
    int edge_cnt    = 0;
    int en_edge_cnt = 0;
    always @(posedge sr_clk) begin
        rx_word = {rx_word[W-2:0], sr_data};
        edge_cnt++;
        if (divide_enable || en_internals) en_edge_cnt++;
    end

    // Cycle monitor: select/clear occupancy, illegal combinations, select gaps.
    int sel_div_cyc = 0, sel_row_cyc = 0, clr_div_cyc = 0, clr_row_cyc = 0;
    int illegal_cyc = 0, low_run = 0, last_gap = 0;
    always @(negedge clk) begin
        if (sr_sel_div) sel_div_cyc++;
        if (sr_sel_row) sel_row_cyc++;
        if (sr_clr_div) clr_div_cyc++;
        if (sr_clr_row) clr_row_cyc++;
        if ((sr_sel_div && sr_sel_row) || (sr_clr_div && sr_clr_row) ||
            ((sr_sel_div || sr_sel_row) && (sr_clr_div || sr_clr_row)))
            illegal_cyc++;
        if (sr_sel_div || sr_sel_row) begin
            if (low_run > 0) last_gap = low_run;
            low_run = 0;
        end else begin
            low_run++;
        end
    end

    // Called at a negedge; returns at the negedge just after the accept edge.
    task automatic offer(input bit tgt, input bit clr, input logic [W-1:0] d, input bit hold);
        cmd_target = tgt;
        cmd_clear  = clr;
        cmd_data   = d;
        cmd_valid  = 1'b1;
        for (int i = 0; i < 300 && !cmd_ready; i++) @(negedge clk);
        check("accept_ready", cmd_ready, 1);
        @(negedge clk);
        if (!hold) begin
            cmd_valid  = 1'b0;
            cmd_target = 1'($urandom_range(0, 1));
            cmd_clear  = 1'($urandom_range(0, 1));
            cmd_data   = W'($urandom);
        end
    endtask

    // Follows one accepted frame to completion and compares it with the
    // frame-level expectations: latency, edges, received word, select/clear
    // occupancy, enable behaviour.
    task automatic finish_frame(input bit tgt, input bit clr, input logic [W-1:0] d,
                                input bit run, input bit wiggle);
        int exp_lat = GUARD + (clr ? HALF : HALF * (2 + 2 * W));
        int exp_sel = clr ? 0 : HALF * (2 + 2 * W);
        int exp_clr = clr ? HALF : 0;
        int e0 = edge_cnt, ee0 = en_edge_cnt, il0 = illegal_cyc;
        int sd0 = sel_div_cyc, sr0 = sel_row_cyc, cd0 = clr_div_cyc, cr0 = clr_row_cyc;
        int n = 1, lat = 0, en_bad = 0;
        bit got_done = 0;
        check("busy_rise", busy, 1);
        check("ready_low", cmd_ready, 0);
        while (n < 400) begin
            if (n >= 2 && (divide_enable || en_internals)) en_bad++;
            if (done) begin
                lat = n - 1;
                got_done = 1;
                break;
            end
            if (wiggle && n == 3) run_req = !run;
            if (wiggle && n == 5) run_req = run;
            @(negedge clk);
            n++;
        end
        check("done_seen", got_done, 1);
        check("latency", lat, exp_lat);
        check("busy_at_done", busy, 0);
        check("ready_at_done", cmd_ready, 0);
        check("edges", edge_cnt - e0, clr ? 0 : W);
        if (!clr) check("word", rx_word, d);
        check("sel_div_cyc", sel_div_cyc - sd0, (tgt == 1'b0) ? exp_sel : 0);
        check("sel_row_cyc", sel_row_cyc - sr0, (tgt == 1'b1) ? exp_sel : 0);
        check("clr_div_cyc", clr_div_cyc - cd0, (tgt == 1'b0) ? exp_clr : 0);
        check("clr_row_cyc", clr_row_cyc - cr0, (tgt == 1'b1) ? exp_clr : 0);
        check("illegal_combo", illegal_cyc - il0, 0);
        check("edge_while_enabled", en_edge_cnt - ee0, 0);
        check("enable_in_frame", en_bad, 0);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("ready_after", cmd_ready, 1);
        check("div_en_after", divide_enable, run);
        check("en_int_after", en_internals, run);
        $display("frame tgt=%0d clr=%0d data=0x%04h run=%0d latency=%0d rx=0x%04h",
                 tgt, clr, d, run, lat, rx_word);
    endtask

    initial begin
        bit tgt, clr, run;
        logic [W-1:0] d;

        repeat (3) @(negedge clk);
        check("rst_outputs",
              {28'd0, sr_sel_div, sr_sel_row, sr_clr_div, sr_clr_row}, 0);
        check("rst_misc",
              {26'd0, sr_clk, sr_data, divide_enable, en_internals, busy, done}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);

        // Divider load, then reload while running.
        run_req = 1'b1;
        repeat (2) @(negedge clk);
        check("enable_idle", divide_enable, 1);
        offer(1'b0, 1'b0, 16'd2, 1'b0);
        finish_frame(1'b0, 1'b0, 16'd2, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        offer(1'b0, 1'b0, 16'd6, 1'b0);
        finish_frame(1'b0, 1'b0, 16'd6, 1'b1, 1'b0);

        // Row-size load and divider clear.
        offer(1'b1, 1'b0, 16'hA5C3, 1'b0);
        finish_frame(1'b1, 1'b0, 16'hA5C3, 1'b1, 1'b0);
        offer(1'b0, 1'b1, 16'hFFFF, 1'b0);
        finish_frame(1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0);

        // Reset during bit 7 high phase: 4 guard + 2 select + 7*4 + 2 low cycles in.
        offer(1'b0, 1'b0, 16'h1234, 1'b0);
        for (int n = 1; n < 37; n++) @(negedge clk);
        check("bit7_hi_clk", sr_clk, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_sel_clr",
              {28'd0, sr_sel_div, sr_sel_row, sr_clr_div, sr_clr_row}, 0);
        check("midrst_misc",
              {26'd0, sr_clk, sr_data, divide_enable, en_internals, busy, done}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", cmd_ready, 1);
        check("post_rst_done", done, 0);
        offer(1'b0, 1'b0, 16'h8001, 1'b0);
        finish_frame(1'b0, 1'b0, 16'h8001, 1'b1, 1'b0);

        // Two queued commands with cmd_valid held throughout.
        offer(1'b0, 1'b0, 16'h1357, 1'b1);
        cmd_target = 1'b1;
        cmd_clear  = 1'b0;
        cmd_data   = 16'hFEDC;
        finish_frame(1'b0, 1'b0, 16'h1357, 1'b1, 1'b0);
        offer(1'b1, 1'b0, 16'hFEDC, 1'b0);
        finish_frame(1'b1, 1'b0, 16'hFEDC, 1'b1, 1'b0);
        check("sel_gap_ok", last_gap >= GUARD + 1, 1);

        // Randomized commands, run_req toggled mid-frame.
        for (int k = 0; k < 12; k++) begin
            tgt = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 3) == 0);
            run = 1'($urandom_range(0, 1));
            d   = W'($urandom);
            if (k == 0) d = '0;
            run_req = run;
            @(negedge clk);
            offer(tgt, clr, d, 1'b0);
            finish_frame(tgt, clr, d, run, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
